// File: rtl/pool2x2_stream_if.sv
// Pixel stream interface for the 2x2 pooling block: input pixels in, pooled pixels out.
interface pool2x2_stream_if #(
   parameter int unsigned DATA_W = 8
);
   logic              mode;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              frame_done;

   modport master (
      output mode, in_valid, in_data,
      input  out_valid, out_data, frame_done
   );

   modport slave (
      input  mode, in_valid, in_data,
      output out_valid, out_data, frame_done
   );
endinterface

// File: rtl/pool2x2_stream.sv
// Streaming 2x2/stride-2 max or average pooling over a raster-order frame.
// A line buffer keeps one combined pair per output column from the even row;
// the odd row merges its own pair with that entry to produce each result.
module pool2x2_stream #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IMG_W  = 28,
   parameter int unsigned IMG_H  = 28
) (
   input logic               clk,
   input logic               rst_n,
   pool2x2_stream_if.slave   bus
);
   localparam int unsigned OUT_W  = IMG_W / 2;
   localparam int unsigned COL_W  = $clog2(IMG_W);
   localparam int unsigned ROW_W  = $clog2(IMG_H);
   localparam int unsigned IDX_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int unsigned PAIR_W = DATA_W + 1;
   localparam int unsigned SUM_W  = DATA_W + 2;
   localparam bit          H_ODD  = (IMG_H % 2) != 0;

   logic [COL_W-1:0]          col;
   logic [ROW_W-1:0]          row;
   logic                      mode_q;
   logic signed [DATA_W-1:0]  left_px;
   logic signed [PAIR_W-1:0]  line_buf [OUT_W];

   logic                      accept_c;
   logic                      first_c;
   logic                      last_col_c;
   logic                      last_row_c;
   logic                      write_pair_c;
   logic                      emit_c;
   logic [IDX_W-1:0]          lb_idx_c;
   logic signed [DATA_W-1:0]  pix_c;
   logic signed [PAIR_W-1:0]  pair_c;
   logic signed [PAIR_W-1:0]  lb_rd_c;
   logic signed [PAIR_W-1:0]  quad_max_c;
   logic signed [SUM_W-1:0]   quad_sum_c;
   logic [DATA_W-1:0]         result_c;

   // Position decode, pair combine and 2x2 result formation
   always_comb begin
      accept_c     = bus.in_valid;
      first_c      = (col == '0) && (row == '0);
      last_col_c   = (col == COL_W'(IMG_W - 1));
      last_row_c   = (row == ROW_W'(IMG_H - 1));
      pix_c        = bus.in_data;
      lb_idx_c     = IDX_W'(col >> 1);
      // An odd-height frame's last row is even and must not disturb the buffer
      write_pair_c = accept_c && !row[0] && col[0] && !(H_ODD && last_row_c);
      emit_c       = accept_c && row[0] && col[0];

      pair_c = '0;
      if (mode_q) begin
         pair_c = PAIR_W'(pix_c) + PAIR_W'(left_px);
      end else begin
         pair_c = (pix_c > left_px) ? PAIR_W'(pix_c) : PAIR_W'(left_px);
      end

      lb_rd_c    = line_buf[lb_idx_c];
      quad_max_c = (pair_c > lb_rd_c) ? pair_c : lb_rd_c;
      quad_sum_c = SUM_W'(pair_c) + SUM_W'(lb_rd_c);
      result_c   = mode_q ? DATA_W'(quad_sum_c >>> 2) : DATA_W'(quad_max_c);
   end

   // Raster counters, mode latch, left-pixel hold and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col            <= '0;
         row            <= '0;
         mode_q         <= 1'b0;
         left_px        <= '0;
         bus.out_valid  <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.out_data   <= '0;
      end else begin
         bus.out_valid  <= emit_c;
         bus.frame_done <= accept_c && last_col_c && last_row_c;
         if (emit_c) begin
            bus.out_data <= result_c;
         end
         if (accept_c) begin
            if (first_c) begin
               mode_q <= bus.mode;
            end
            if (!col[0]) begin
               left_px <= pix_c;
            end
            if (last_col_c) begin
               col <= '0;
               row <= last_row_c ? '0 : row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(1);
            end
         end
      end
   end

   // Line buffer: every entry is written on the even row before the odd row reads it
   always_ff @(posedge clk) begin
      if (write_pair_c) begin
         line_buf[lb_idx_c] <= pair_c;
      end
   end
endmodule

// File: tb/tb_pool2x2_stream.sv
// Bench for pool2x2_stream: four instances (2x2, 4x4, 5x3, 28x28) share one driver,
// a cycle-stamped scoreboard checks every output and frame_done pulse.
module tb_pool2x2_stream;
   logic       clk;
   logic       rst_n;
   logic       drv_valid;
   logic       drv_mode;
   logic [7:0] drv_data;
   int         sel;

   logic       mon_valid;
   logic       mon_fd;
   logic [7:0] mon_data;

   pool2x2_stream_if #(.DATA_W(8)) if_a ();
   pool2x2_stream_if #(.DATA_W(8)) if_b ();
   pool2x2_stream_if #(.DATA_W(8)) if_c ();
   pool2x2_stream_if #(.DATA_W(8)) if_d ();

   assign if_a.in_valid = drv_valid && (sel == 0);
   assign if_a.in_data  = drv_data;
   assign if_a.mode     = drv_mode;
   assign if_b.in_valid = drv_valid && (sel == 1);
   assign if_b.in_data  = drv_data;
   assign if_b.mode     = drv_mode;
   assign if_c.in_valid = drv_valid && (sel == 2);
   assign if_c.in_data  = drv_data;
   assign if_c.mode     = drv_mode;
   assign if_d.in_valid = drv_valid && (sel == 3);
   assign if_d.in_data  = drv_data;
   assign if_d.mode     = drv_mode;

   pool2x2_stream #(.DATA_W(8), .IMG_W(2),  .IMG_H(2))  dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   pool2x2_stream #(.DATA_W(8), .IMG_W(4),  .IMG_H(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
   pool2x2_stream #(.DATA_W(8), .IMG_W(5),  .IMG_H(3))  dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
   pool2x2_stream #(.DATA_W(8), .IMG_W(28), .IMG_H(28)) dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

   always_comb begin
      case (sel)
         0:       begin mon_valid = if_a.out_valid; mon_data = if_a.out_data; mon_fd = if_a.frame_done; end
         1:       begin mon_valid = if_b.out_valid; mon_data = if_b.out_data; mon_fd = if_b.frame_done; end
         2:       begin mon_valid = if_c.out_valid; mon_data = if_c.out_data; mon_fd = if_c.frame_done; end
         default: begin mon_valid = if_d.out_valid; mon_data = if_d.out_data; mon_fd = if_d.frame_done; end
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_out = 0;
   int n_fd  = 0;

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      int p [4];
      bit md;
      int exp;
   } vec_t;

   exp_t       sb [$];
   int         fd_q [$];
   logic [7:0] got_q [$];
   int         fd_log [$];
   int         frame [784];
   vec_t       vt [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         total++;
         if (!mon_valid || mon_data !== sb[0].data) begin
            bad++;
            $display("FAIL out_data cyc=%0d got valid=%0b data=%0d want data=%0d",
                     cyc, mon_valid, $signed(mon_data), $signed(sb[0].data));
         end
         void'(sb.pop_front());
      end else if (mon_valid) begin
         total++;
         bad++;
         $display("FAIL spurious_out cyc=%0d got data=%0d want no output", cyc, $signed(mon_data));
      end
      if (mon_valid) begin
         n_out++;
         got_q.push_back(mon_data);
      end
      if (fd_q.size() > 0 && fd_q[0] == cyc) begin
         total++;
         if (!mon_fd) begin
            bad++;
            $display("FAIL frame_done cyc=%0d got 0 want 1", cyc);
         end
         void'(fd_q.pop_front());
      end else if (mon_fd) begin
         total++;
         bad++;
         $display("FAIL spurious_frame_done cyc=%0d got 1 want 0", cyc);
      end
      if (mon_fd) begin
         n_fd++;
         fd_log.push_back(cyc);
      end
   end

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   // Independent model of one window whose bottom-right pixel is frame[i]
   function automatic logic [7:0] golden(input int i, input int w, input bit md);
      int a, b, c, d, r;
      a = frame[i - w - 1];
      b = frame[i - w];
      c = frame[i - 1];
      d = frame[i];
      if (md) begin
         r = (a + b + c + d) >>> 2;
      end else begin
         r = a;
         if (b > r) r = b;
         if (c > r) r = c;
         if (d > r) r = d;
      end
      return 8'(r);
   endfunction

   function automatic int s8(input int v);
      int m;
      m = v % 256;
      return (m > 127) ? m - 256 : m;
   endfunction

   // Drive up to stop_at pixels of a w x h frame; expectations pushed as pixels go out
   task automatic drive_frame(input int w, input int h, input bit md, input bit gaps,
                              input bit toggle, input int stop_at);
      int n;
      n = w * h;
      if (stop_at < n) n = stop_at;
      for (int i = 0; i < n; i++) begin
         int   x;
         int   y;
         exp_t e;
         @(negedge clk);
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               drv_valid = 1'b0;
               drv_data  = 8'($urandom);
               drv_mode  = 1'($urandom);
               @(negedge clk);
            end
         end
         x = i % w;
         y = i / w;
         drv_valid = 1'b1;
         drv_data  = 8'(frame[i]);
         drv_mode  = (i == 0) ? md : (toggle ? !md : md);
         if ((x % 2 == 1) && (y % 2 == 1)) begin
            e.cyc  = cyc + 1;
            e.data = golden(i, w, md);
            sb.push_back(e);
         end
         if (i == w * h - 1) fd_q.push_back(cyc + 1);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         drv_valid = 1'b0;
         drv_data  = 8'($urandom);
      end
   endtask

   task automatic add_vec(input int a, input int b, input int c, input int d,
                          input bit md, input int exp);
      vec_t v;
      v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
      v.md   = md;
      v.exp  = exp;
      vt.push_back(v);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int nb;
      int fb;
      int want4 [4];
      rst_n     = 1'b0;
      drv_valid = 1'b0;
      drv_mode  = 1'b0;
      drv_data  = 8'h00;
      sel       = 0;

      // Single-window frames on the 2x2 instance: {pixels, mode, expected}
      add_vec(   1,    2,    3,    4, 1'b0,    4);
      add_vec(   1,    2,    3,    5, 1'b1,    2);
      add_vec(  -1,   -1,   -1,   -2, 1'b1,   -2);
      add_vec(-128, -128, -128, -128, 1'b1, -128);
      add_vec(-128,   -5,   -7, -100, 1'b0,   -5);
      add_vec( 127,  127,  127,  127, 1'b1,  127);
      add_vec(  -1,   -2,   -3,   -4, 1'b0,   -1);
      add_vec( 127,  127,  127, -128, 1'b1,   63);
      add_vec( 127, -128,    0,    5, 1'b0,  127);
      add_vec(-128,  127,    0,    0, 1'b1,   -1);

      // Reset state of every instance
      repeat (3) @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         sel = s;
         #1;
         check("rst_out_valid", int'(mon_valid), 0);
         check("rst_frame_done", int'(mon_fd), 0);
         check("rst_out_data", int'(mon_data), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven windows; mode flips after pixel 0 and must be ignored
      sel = 0;
      foreach (vt[k]) begin
         for (int j = 0; j < 4; j++) frame[j] = vt[k].p[j];
         drive_frame(2, 2, vt[k].md, 1'b0, 1'b1, 4);
         idle(3);
         check("vec_hold_data", int'($signed(mon_data)), vt[k].exp);
         check("vec_idle_valid", int'(mon_valid), 0);
      end

      // 4x4 average frame with hand-derived results
      sel = 1;
      idle(1);
      frame[0:15] = '{-128, -128, -128, -127,
                      -128, -128,    0,    0,
                         1,    2,   -1,   -1,
                         3,    5,   -1,   -2};
      want4 = '{-128, -64, 2, -2};
      base = got_q.size();
      nb   = n_out;
      drive_frame(4, 4, 1'b1, 1'b0, 1'b1, 16);
      idle(4);
      check("avg4_count", n_out - nb, 4);
      for (int k = 0; k < 4; k++) begin
         if (base + k < got_q.size()) check("avg4_value", int'($signed(got_q[base + k])), want4[k]);
      end

      // 5x3 ramp: odd column and odd row are consumed without output
      sel = 2;
      idle(1);
      for (int i = 0; i < 15; i++) frame[i] = i;
      base = got_q.size();
      nb   = n_out;
      fb   = n_fd;
      drive_frame(5, 3, 1'b0, 1'b0, 1'b0, 15);
      idle(6);
      check("odd_count", n_out - nb, 2);
      check("odd_fd_count", n_fd - fb, 1);
      if (base + 1 < got_q.size()) begin
         check("odd_out0", int'(got_q[base]), 6);
         check("odd_out1", int'(got_q[base + 1]), 8);
      end

      // 28x28 ramp in max mode
      sel = 3;
      idle(1);
      for (int i = 0; i < 784; i++) frame[i] = s8(i);
      base = got_q.size();
      nb   = n_out;
      drive_frame(28, 28, 1'b0, 1'b0, 1'b0, 784);
      idle(4);
      check("ramp_count", n_out - nb, 196);
      if (base < got_q.size()) check("ramp_out0", int'($signed(got_q[base])), 29);

      // Random data, random gaps, mode toggled mid-frame, both modes
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 784; i++) frame[i] = int'($urandom_range(0, 255)) - 128;
         nb = n_out;
         fb = n_fd;
         drive_frame(28, 28, 1'(m), 1'b1, 1'b1, 784);
         idle(4);
         check("rand_count", n_out - nb, 196);
         check("rand_fd_count", n_fd - fb, 1);
      end

      // Reset after 100 pixels, then a full frame from pixel (0,0)
      for (int i = 0; i < 784; i++) frame[i] = int'($urandom_range(0, 255)) - 128;
      drive_frame(28, 28, 1'b0, 1'b0, 1'b0, 100);
      @(negedge clk);
      drv_valid = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", int'(mon_valid), 0);
      check("midrst_out_data", int'(mon_data), 0);
      check("midrst_pending", sb.size(), 0);
      rst_n = 1'b1;
      nb = n_out;
      drive_frame(28, 28, 1'b1, 1'b0, 1'b0, 784);
      idle(4);
      check("postrst_count", n_out - nb, 196);

      // Back-to-back frames, no idle cycles between them
      for (int i = 0; i < 784; i++) frame[i] = int'($urandom_range(0, 255)) - 128;
      nb = n_out;
      fb = n_fd;
      drive_frame(28, 28, 1'b0, 1'b0, 1'b0, 784);
      drive_frame(28, 28, 1'b1, 1'b0, 1'b0, 784);
      idle(4);
      check("b2b_count", n_out - nb, 392);
      check("b2b_fd_count", n_fd - fb, 2);
      if (fd_log.size() >= 2) check("b2b_fd_spacing", fd_log[fd_log.size() - 1] - fd_log[fd_log.size() - 2], 784);

      check("sb_drained", sb.size(), 0);
      check("fd_drained", fd_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pool2x2_stream.md
POOL2X2_STREAM -- requirements
Module: pool2x2_stream

Interface
REQ-001 Parameter DATA_W, default 8: pixel width in bits, two's-complement signed.
REQ-002 Parameter IMG_W, default 28: input frame width in pixels, range 2..1024.
REQ-003 Parameter IMG_H, default 28: input frame height in pixels, range 2..1024.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port mode, input, 1: pooling mode, 0 = max, 1 = average.
REQ-007 Port in_valid, input, 1: in_data holds a pixel this cycle.
REQ-008 Port in_data, input, DATA_W: pixel in raster order (row-major, left to right).
REQ-009 Port out_valid, output, 1: out_data holds a pooled result this cycle.
REQ-010 Port out_data, output, DATA_W: pooled pixel in raster order of the OUT_W x OUT_H grid.
REQ-011 Port frame_done, output, 1: one-cycle pulse marking the end of a frame.

Function
REQ-012 OUT_W = IMG_W/2 and OUT_H = IMG_H/2, both integer floor; window is 2x2 with stride 2 and no padding.
REQ-013 A pixel is accepted on each rising edge where in_valid=1; in_valid gaps of any length are legal and do not change state.
REQ-014 Internal counters: col 0..IMG_W-1 and row 0..IMG_H-1; col advances per accepted pixel and wraps to 0 with row+1; after (IMG_W-1, IMG_H-1) both wrap to 0.
REQ-015 Odd IMG_W: pixels at col = IMG_W-1 are consumed and ignored. Odd IMG_H: row IMG_H-1 is consumed and ignored.
REQ-016 Even row (row[0]=0), odd col: combine the pixel with its left neighbour into one pair entry, and store it in a line buffer of OUT_W entries at index col>>1.
REQ-017 Pair entry: max mode holds the signed max; average mode holds the signed sum, DATA_W+1 bits.
REQ-018 Odd row, odd col, within the OUT grid: combine the current pair with the stored line-buffer entry to form the result.
REQ-019 Max result: signed maximum of the 4 pixels.
REQ-020 Average result: signed sum of the 4 pixels (DATA_W+2 bits), arithmetic right shift by 2 (floor toward minus infinity), truncated to DATA_W bits.
REQ-021 out_valid rises for exactly one cycle, in the cycle after the edge that accepts the bottom-right pixel of a window; out_data is registered and valid in that cycle.
REQ-022 Each frame produces exactly OUT_W*OUT_H results.
REQ-023 mode is sampled when pixel (0,0) is accepted; changes to mode mid-frame have no effect until the next frame.
REQ-024 frame_done pulses for one cycle, in the cycle after the edge that accepts pixel (IMG_W-1, IMG_H-1); it coincides with the final out_valid when IMG_W and IMG_H are both even.
REQ-025 Back-to-back frames need no idle cycles; the line buffer is overwritten each frame and is never cleared.
REQ-026 out_data holds its last value while out_valid=0.

Reset
REQ-027 While rst_n=0 at a rising edge: out_valid=0, frame_done=0, out_data=0, col=0, row=0, latched mode=0.
REQ-028 Reset asserted mid-frame discards the partial frame; the first pixel accepted after release is treated as pixel (0,0).
REQ-029 The line buffer needs no reset, because every entry is written before it is read.

Verification
REQ-030 Ramp test: 28x28, max mode, pixel i = i mod 256 treated as signed -> 196 outputs; output 0 = 29; every output equals the golden signed max of its window.
REQ-031 Average test: 4x4, mode=1, frame {-128,-128,-128,-127, ...}; first window {-128,-128,-128,-128} -> -128; window {1,2,3,5} -> 2; window {-1,-1,-1,-2} -> -2.
REQ-032 Random test: 28x28 with random in_valid gaps, both modes; mode toggled mid-frame -> results follow the mode latched at pixel 0; exactly 196 outputs plus one frame_done.
REQ-033 Odd-dimension test: 5x3 ramp 0..14 -> outputs {6, 8}; frame_done one cycle after pixel 14 is accepted; no output after it.
REQ-034 Reset test: reset after 100 pixels of a 28x28 frame, then a full frame -> no stale output; exactly 196 correct outputs follow.
REQ-035 Back-to-back test: two 28x28 frames with no gap -> 392 correct outputs and 2 frame_done pulses, spaced 784 accepted pixels apart.
